fetch_unit: RTL and testbench

Instruction fetch front end of the pipelined RISC-V core: it produces the instruction stream that the decode stage consumes. It generates the program counter, issues in-order read requests to instruction memory over a request/grant/response handshake, and buffers the returned words with their PCs. It presents one instruction per cycle to decode under stall back-pressure, and discards wrong-path fetches on an execute-stage redirect (branch/jump).

---
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_fetch_unit.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Generates the program counter, issues in-order
// read requests to instruction memory over a req/gnt/rvalid handshake, and
// buffers returned words with their PCs until decode takes them. Wrong-path
// responses still in flight at a redirect are counted and silently dropped.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   imem_req        request valid (credit available, no redirect, not in reset)
//   imem_addr       word-aligned fetch address (current pc_q)
//   imem_gnt        request accepted this cycle
//   imem_rvalid     response valid (in order, one per granted request)
//   imem_rdata      returned instruction word
//   StallD          decode cannot accept this cycle
//   PCSrcE          redirect from execute (taken branch / jump)
//   PCTargetE       redirect target address
//   ValidD          InstrD/PCD/PCPlus4D carry a real instruction
//   InstrD          instruction to decode (NOP when !ValidD)
//   PCD             PC of InstrD (0 when !ValidD)
//   PCPlus4D        PCD + 4 (0 when !ValidD)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);

    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = PW + 1;   // counters must hold the value DEPTH
    localparam int          OW  = CW + 2;   // room for the sum of three counters
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Program counter of the next request.
    logic [31:0]   pc_q;

    // Pending FIFO: PC of every granted request whose response has not arrived.
    logic [31:0]   pend_pc [DEPTH];
    logic [PW-1:0] pend_rd;
    logic [PW-1:0] pend_wr;
    logic [CW-1:0] pend_cnt;

    // Instruction buffer: returned words with their PCs, head drives decode.
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc    [DEPTH];
    logic [PW-1:0] buf_rd;
    logic [PW-1:0] buf_wr;
    logic [CW-1:0] buf_cnt;

    // Responses still owed by memory for requests made before a redirect.
    logic [CW-1:0] disc_cnt;

    logic          pop;
    logic          grant;
    logic          resp_drop;
    logic          resp_take;
    logic [OW-1:0] occupancy;

    // -------------------------------------------------------------------------
    // Decode-side outputs: read straight from the buffer head.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ValidD   = 1'b0;
        InstrD   = NOP;
        PCD      = '0;
        PCPlus4D = '0;
        if (!rst && buf_cnt != '0) begin
            ValidD   = 1'b1;
            InstrD   = buf_instr[buf_rd];
            PCD      = buf_pc[buf_rd];
            PCPlus4D = buf_pc[buf_rd] + 32'd4;
        end
    end

    assign pop = ValidD && !StallD && !PCSrcE;

    // Credit: everything already granted (wanted or stale) plus everything
    // buffered must fit in DEPTH; a pop this cycle frees one slot early so the
    // pipeline can sustain one instruction per cycle.
    assign occupancy = OW'(pend_cnt) + OW'(buf_cnt) + OW'(disc_cnt) - OW'(pop);
    assign imem_req  = !rst && !PCSrcE && (occupancy < OW'(DEPTH));
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;

    // A response first pays off any outstanding discards; otherwise it answers
    // the oldest pending request. A response with neither is ignored.
    assign resp_drop = imem_rvalid && (disc_cnt != '0);
    assign resp_take = imem_rvalid && (disc_cnt == '0) && (pend_cnt != '0);

    // -------------------------------------------------------------------------
    // Control state.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            pend_rd  <= '0;
            pend_wr  <= '0;
            pend_cnt <= '0;
            buf_rd   <= '0;
            buf_wr   <= '0;
            buf_cnt  <= '0;
            disc_cnt <= '0;
        end else if (PCSrcE) begin
            pc_q     <= PCTargetE;
            pend_rd  <= '0;
            pend_wr  <= '0;
            pend_cnt <= '0;
            buf_rd   <= '0;
            buf_wr   <= '0;
            buf_cnt  <= '0;
            // Every request still unanswered after this edge becomes a discard.
            // A response arriving now settles one of them (pending or already
            // discarded) and its word is dropped, so it is not counted again.
            disc_cnt <= disc_cnt + pend_cnt - CW'(resp_drop || resp_take);
        end else begin
            if (grant) begin
                pc_q    <= pc_q + 32'd4;
                pend_wr <= pend_wr + PW'(1);
            end
            if (resp_take) begin
                pend_rd <= pend_rd + PW'(1);
                buf_wr  <= buf_wr + PW'(1);
            end
            if (pop) begin
                buf_rd <= buf_rd + PW'(1);
            end
            if (resp_drop) begin
                disc_cnt <= disc_cnt - CW'(1);
            end
            pend_cnt <= pend_cnt + CW'(grant) - CW'(resp_take);
            // Push and pop in the same cycle leave occupancy unchanged; with a
            // full buffer the write lands in the slot being read out this cycle.
            buf_cnt  <= buf_cnt + CW'(resp_take) - CW'(pop);
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage.
    // -------------------------------------------------------------------------
    // NOTE: storage arrays are not reset; the counters and pointers above decide
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (!rst && !PCSrcE) begin
            if (grant) begin
                pend_pc[pend_wr] <= pc_q;
            end
            if (resp_take) begin
                buf_instr[buf_wr] <= imem_rdata;
                buf_pc[buf_wr]    <= pend_pc[pend_rd];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        StallD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .StallD      (StallD),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .ValidD      (ValidD),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D)
    );

    always #5 clk = ~clk;

    // Memory transactions granted but not yet answered. Each carries the epoch
    // it was issued in; a redirect or reset opens a new epoch, so any response
    // from an older epoch is wrong-path and must never reach decode.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] pc;
        int          due;
        int          epoch;
    } mem_t;

    mem_t        memq[$];
    logic [31:0] m_buf[$];     // PCs returned and waiting for decode, oldest first
    logic [31:0] m_fetch_pc;   // address the next request must carry
    int          m_epoch;
    int          cyc;
    int          g_lat_min;
    int          g_lat_max;
    int          g_gnt_pct;
    int          n_cmp;
    int          n_err;

    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_instr, obs_pcd, obs_pc4;
    logic        exp_req, exp_valid;
    logic [31:0] exp_instr, exp_pcd, exp_pc4;
    logic [129:0] obs_vec, exp_vec;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One clock cycle: drive inputs, emulate memory, sample outputs, compute
    // what the model expects, then advance the model across the edge.
    task automatic tick(input logic r, input logic s, input logic p, input logic [31:0] t);
        logic deliver;
        logic pop_e;
        logic gnt_now;
        mem_t d;
        mem_t e;
        d = '0;
        rst       = r;
        StallD    = s;
        PCSrcE    = p;
        PCTargetE = t;
        gnt_now   = (int'($urandom_range(99)) < g_gnt_pct);
        imem_gnt  = gnt_now;
        deliver   = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rvalid = deliver;
        imem_rdata  = deliver ? word_of(memq[0].addr) : $urandom;
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = ValidD;
        obs_instr = InstrD;
        obs_pcd   = PCD;
        obs_pc4   = PCPlus4D;

        exp_valid = !r && (m_buf.size() > 0);
        exp_pcd   = exp_valid ? m_buf[0] : 32'h0;
        exp_instr = exp_valid ? word_of(m_buf[0]) : NOP;
        exp_pc4   = exp_valid ? m_buf[0] + 32'd4 : 32'h0;
        pop_e     = exp_valid && !s && !p;
        exp_req   = !r && !p && ((memq.size() + m_buf.size() - int'(pop_e)) < DEPTH);
        exp_vec   = {exp_req, exp_req ? m_fetch_pc : 32'h0, exp_valid, exp_instr, exp_pcd, exp_pc4};
        obs_vec   = {obs_req, exp_req ? obs_addr : 32'h0, obs_valid, obs_instr, obs_pcd, obs_pc4};

        @(posedge clk);
        #1;
        if (deliver) d = memq.pop_front();
        if (obs_req && gnt_now) begin
            e.addr  = obs_addr;
            e.pc    = m_fetch_pc;
            e.due   = cyc + int'($urandom_range(g_lat_max, g_lat_min));
            e.epoch = m_epoch;
            memq.push_back(e);
        end
        if (r) begin
            m_buf.delete();
            m_fetch_pc = RESET_PC;
            m_epoch++;
        end else if (p) begin
            m_buf.delete();
            m_fetch_pc = t;
            m_epoch++;
        end else begin
            if (pop_e) void'(m_buf.pop_front());
            if (deliver && d.epoch == m_epoch) m_buf.push_back(d.pc);
            if (exp_req && gnt_now) m_fetch_pc = m_fetch_pc + 32'd4;
        end
        cyc++;
    endtask

    // Hold reset until every outstanding memory response has drained.
    task automatic do_reset();
        for (int k = 0; k < 30; k++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            if (k >= 1 && memq.size() == 0) break;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if ({obs_req, obs_valid, obs_instr, obs_pcd, obs_pc4} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
                n_err++;
                $display("FAIL reset_outputs k=%0d got req=%b valid=%b instr=%h pcd=%h pc4=%h want 0 0 %h 0 0",
                         k, obs_req, obs_valid, obs_instr, obs_pcd, obs_pc4, NOP);
            end
        end
    endtask

    task automatic test_straight_line();
        logic        want_valid;
        logic [31:0] want_pc;
        g_lat_min = 1; g_lat_max = 1; g_gnt_pct = 100;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL straight_model k=%0d got %h want %h", k, obs_vec, exp_vec);
            end
            want_valid = (k >= 2);
            want_pc    = RESET_PC + 32'(4 * (k - 2));
            n_cmp++;
            if (obs_valid !== want_valid ||
                (want_valid && (obs_pcd !== want_pc || obs_instr !== word_of(want_pc) ||
                                obs_pc4 !== want_pc + 32'd4))) begin
                n_err++;
                $display("FAIL straight_seq k=%0d got valid=%b pcd=%h instr=%h pc4=%h want valid=%b pcd=%h",
                         k, obs_valid, obs_pcd, obs_instr, obs_pc4, want_valid, want_pc);
            end
            if (k == 0) begin
                n_cmp++;
                if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
                    n_err++;
                    $display("FAIL first_request got req=%b addr=%h want 1 %h", obs_req, obs_addr, RESET_PC);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] held;
        held = m_buf[0];
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL stall_model k=%0d got %h want %h", k, obs_vec, exp_vec);
            end
            n_cmp++;
            if (obs_valid !== 1'b1 || obs_pcd !== held || obs_instr !== word_of(held)) begin
                n_err++;
                $display("FAIL stall_hold k=%0d got valid=%b pcd=%h instr=%h want 1 %h %h",
                         k, obs_valid, obs_pcd, obs_instr, held, word_of(held));
            end
            if (k >= 2) begin
                n_cmp++;
                if (obs_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_credit k=%0d got req=%b want 0", k, obs_req);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL release_model k=%0d got %h want %h", k, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] seen[2];
        int          n_seen;
        do_reset();
        g_lat_min = 3; g_lat_max = 3; g_gnt_pct = 100;
        n_seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, (k == 2), 32'h0000_0100);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL redir_pre_model k=%0d got %h want %h", k, obs_vec, exp_vec);
            end
        end
        for (int k = 0; k < 20 && n_seen < 2; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL redir_model k=%0d got %h want %h", k, obs_vec, exp_vec);
            end
            if (obs_valid === 1'b1) begin
                seen[n_seen] = obs_pcd;
                n_seen++;
            end
        end
        n_cmp++;
        if (n_seen < 2) begin
            n_err++;
            $display("FAIL redir_timeout got %0d valid instructions want 2", n_seen);
        end else if (seen[0] !== 32'h0000_0100 || seen[1] !== 32'h0000_0104) begin
            n_err++;
            $display("FAIL redir_target got %h %h want 00000100 00000104", seen[0], seen[1]);
        end
    endtask

    task automatic test_redirect_full_stall();
        logic found;
        do_reset();
        g_lat_min = 1; g_lat_max = 1; g_gnt_pct = 100;
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL fill_model k=%0d got %h want %h", k, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (obs_valid !== 1'b1 || obs_req !== 1'b0 || obs_pcd !== RESET_PC) begin
            n_err++;
            $display("FAIL fill_full got valid=%b req=%b pcd=%h want 1 0 %h", obs_valid, obs_req, obs_pcd, RESET_PC);
        end
        tick(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        n_cmp++;
        if (obs_vec !== exp_vec) begin
            n_err++;
            $display("FAIL flush_model got %h want %h", obs_vec, exp_vec);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h0000_0040) begin
            n_err++;
            $display("FAIL flush_after got valid=%b req=%b addr=%h want 0 1 00000040", obs_valid, obs_req, obs_addr);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            if (obs_valid === 1'b1) begin
                found = 1'b1;
                n_cmp++;
                if (obs_pcd !== 32'h0000_0040 || obs_instr !== word_of(32'h0000_0040)) begin
                    n_err++;
                    $display("FAIL flush_target got pcd=%h instr=%h want 00000040 %h",
                             obs_pcd, obs_instr, word_of(32'h0000_0040));
                end
            end
        end
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL flush_timeout got no valid instruction want pcd=00000040");
        end
    endtask

    task automatic test_grant_gaps();
        logic        s;
        logic        p;
        logic [31:0] tgt;
        do_reset();
        g_lat_min = 1; g_lat_max = 3; g_gnt_pct = 60;
        for (int k = 0; k < 600; k++) begin
            s   = ($urandom_range(3) == 0);
            p   = ($urandom_range(39) == 0);
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            tick(1'b0, s, p, tgt);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL gaps_model k=%0d got %h want %h", k, obs_vec, exp_vec);
            end
            n_cmp++;
            if (memq.size() > DEPTH) begin
                n_err++;
                $display("FAIL gaps_inflight k=%0d got %0d outstanding want <= %0d", k, memq.size(), DEPTH);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seen[2];
        logic [31:0] seen4[2];
        int          n_seen;
        do_reset();
        g_lat_min = 1; g_lat_max = 1; g_gnt_pct = 100;
        n_seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, (k == 3), 32'hFFFF_FFFC);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL wrap_pre_model k=%0d got %h want %h", k, obs_vec, exp_vec);
            end
        end
        for (int k = 0; k < 12 && n_seen < 2; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL wrap_model k=%0d got %h want %h", k, obs_vec, exp_vec);
            end
            if (obs_valid === 1'b1) begin
                seen[n_seen]  = obs_pcd;
                seen4[n_seen] = obs_pc4;
                n_seen++;
            end
        end
        n_cmp++;
        if (n_seen < 2) begin
            n_err++;
            $display("FAIL wrap_timeout got %0d valid instructions want 2", n_seen);
        end else if (seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0 || seen4[0] !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_seq got pcd %h %h pc4 %h want fffffffc 00000000 pc4 00000000",
                     seen[0], seen[1], seen4[0]);
        end
    endtask

    task automatic test_mid_reset();
        logic found;
        g_lat_min = 3; g_lat_max = 3; g_gnt_pct = 100;
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL midrst_pre_model k=%0d got %h want %h", k, obs_vec, exp_vec);
            end
        end
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if ({obs_req, obs_valid, obs_instr, obs_pcd, obs_pc4} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
                n_err++;
                $display("FAIL midrst_outputs k=%0d got req=%b valid=%b instr=%h pcd=%h pc4=%h want 0 0 %h 0 0",
                         k, obs_req, obs_valid, obs_instr, obs_pcd, obs_pc4, NOP);
            end
            if (k >= 1 && memq.size() == 0) break;
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC || obs_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_restart got req=%b addr=%h valid=%b want 1 %h 0", obs_req, obs_addr, obs_valid, RESET_PC);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL midrst_model k=%0d got %h want %h", k, obs_vec, exp_vec);
            end
            if (obs_valid === 1'b1) begin
                found = 1'b1;
                n_cmp++;
                if (obs_pcd !== RESET_PC || obs_instr !== word_of(RESET_PC)) begin
                    n_err++;
                    $display("FAIL midrst_first got pcd=%h instr=%h want %h %h",
                             obs_pcd, obs_instr, RESET_PC, word_of(RESET_PC));
                end
            end
        end
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL midrst_timeout got no valid instruction want pcd=%h", RESET_PC);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        m_epoch = 0;
        m_fetch_pc = RESET_PC;
        g_lat_min = 1;
        g_lat_max = 1;
        g_gnt_pct = 100;
        rst = 1'b1;
        StallD = 1'b0;
        PCSrcE = 1'b0;
        PCTargetE = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;

        test_reset();
        test_straight_line();
        test_back_pressure();
        test_redirect_inflight();
        test_redirect_full_stall();
        test_grant_gaps();
        test_wrap();
        test_mid_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
